// File: rtl/teeter_pkg.sv
// Shared types and constants for the teeter hole/fall logic.
package teeter_pkg;

  localparam int COORD_W = 10;
  localparam int WIN_IDX = 0;

  typedef enum logic [1:0] {IDLE, SCAN, FALL, DONE} state_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hole_dist_cmp.sv
// Combinational capture test: hit when dx^2 + dy^2 < RADIUS^2.
module hole_dist_cmp
  import teeter_pkg::*;
#(
  parameter int RADIUS = 16
) (
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [COORD_W-1:0] i_hx,
  input  logic [COORD_W-1:0] i_hy,
  output logic               o_hit
);

  localparam logic [20:0] R2 = 21'(RADIUS * RADIUS);

  logic [COORD_W-1:0] w_dx, w_dy;
  logic [19:0]        w_dx2, w_dy2;
  logic [20:0]        w_sum;

  // Absolute differences, squares and strict compare against the capture radius.
  always_comb begin
    w_dx  = (i_bx >= i_hx) ? (i_bx - i_hx) : (i_hx - i_bx);
    w_dy  = (i_by >= i_hy) ? (i_by - i_hy) : (i_hy - i_by);
    w_dx2 = 20'(w_dx) * 20'(w_dx);
    w_dy2 = 20'(w_dy) * 20'(w_dy);
    w_sum = 21'(w_dx2) + 21'(w_dy2);
    o_hit = (w_sum < R2);
  end

endmodule

// File: rtl/hole_fall_sequencer.sv
// Scans win + fail holes one per cycle through a shared comparator, runs the
// fall animation on a hit and holds the win/fail result until acknowledged.
module hole_fall_sequencer
  import teeter_pkg::*;
#(
  parameter  int RADIUS       = 16,
  parameter  int FAILHOLE_NUM = 7,
  parameter  int FALL_FRAMES  = 8,
  localparam int FF_W         = (clog2(FALL_FRAMES) < 1) ? 1 : clog2(FALL_FRAMES),
  localparam int HIDX_W       = clog2(FAILHOLE_NUM + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic                            i_frame_tick,
  input  logic [COORD_W-1:0]              i_bl_x,
  input  logic [COORD_W-1:0]              i_bl_y,
  input  logic [COORD_W-1:0]              i_wh_pos_x,
  input  logic [COORD_W-1:0]              i_wh_pos_y,
  input  logic [COORD_W*FAILHOLE_NUM-1:0] i_fh_pos_x,
  input  logic [COORD_W*FAILHOLE_NUM-1:0] i_fh_pos_y,
  input  logic [FAILHOLE_NUM-1:0]         i_fh_valid,
  input  logic [COORD_W-1:0]              i_bl_pos_initial_x,
  input  logic [COORD_W-1:0]              i_bl_pos_initial_y,
  input  logic                            i_ack,
  output logic                            o_busy,
  output logic                            o_falling,
  output logic [FF_W-1:0]                 o_fall_frame,
  output logic [HIDX_W-1:0]               o_hole_idx,
  output logic [COORD_W-1:0]              o_pos_fall_x,
  output logic [COORD_W-1:0]              o_pos_fall_y,
  output logic                            o_win,
  output logic                            o_fail
);

  localparam logic [HIDX_W-1:0] LAST_K     = HIDX_W'(FAILHOLE_NUM);
  localparam logic [FF_W-1:0]   LAST_FRAME = FF_W'(FALL_FRAMES - 1);

  state_t              r_state, w_next;
  logic [COORD_W-1:0]  r_bx, r_by;
  logic [HIDX_W-1:0]   r_k;
  logic                r_cmp_vld, r_cmp_hit;
  logic [HIDX_W-1:0]   r_cmp_k;
  logic [COORD_W-1:0]  r_cmp_x, r_cmp_y;
  logic                r_busy, r_falling, r_win, r_fail;
  logic [FF_W-1:0]     r_fall_frame;
  logic [HIDX_W-1:0]   r_hole_idx;
  logic [COORD_W-1:0]  r_pos_x, r_pos_y;
  logic [COORD_W-1:0]  w_hx, w_hy;
  logic                w_cand_vld, w_hit;
  logic                w_scan_hit, w_scan_end, w_last_tick, w_abort;

  // Candidate mux: k=0 is the win hole, k=j+1 is fail slot j (gated by its valid bit).
  always_comb begin
    w_hx       = i_wh_pos_x;
    w_hy       = i_wh_pos_y;
    w_cand_vld = (r_k == '0);
    for (int j = 0; j < FAILHOLE_NUM; j++) begin
      if (r_k == HIDX_W'(j + 1)) begin
        w_hx       = i_fh_pos_x[COORD_W*j +: COORD_W];
        w_hy       = i_fh_pos_y[COORD_W*j +: COORD_W];
        w_cand_vld = i_fh_valid[j];
      end
    end
  end

  hole_dist_cmp #(.RADIUS(RADIUS)) u_cmp (
    .i_bx (r_bx),
    .i_by (r_by),
    .i_hx (w_hx),
    .i_hy (w_hy),
    .o_hit(w_hit)
  );

  assign w_scan_hit  = r_cmp_vld & r_cmp_hit;
  assign w_scan_end  = r_cmp_vld & (r_cmp_k == LAST_K);
  assign w_last_tick = i_frame_tick & (r_fall_frame == LAST_FRAME);
  assign w_abort     = ~i_enable & ((r_state == SCAN) | (r_state == FALL));

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_frame_tick && i_enable) w_next = SCAN;
      SCAN:    if (!i_enable)      w_next = IDLE;
               else if (w_scan_hit) w_next = FALL;
               else if (w_scan_end) w_next = IDLE;
      FALL:    if (!i_enable)       w_next = IDLE;
               else if (w_last_tick) w_next = DONE;
      DONE:    if (i_ack)           w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered busy/falling flags decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_falling <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != IDLE);
      r_falling <= (w_next == FALL);
    end
  end

  // Scan pipeline: latch ball on start, then register one compare result per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bx      <= '0;
      r_by      <= '0;
      r_k       <= '0;
      r_cmp_vld <= 1'b0;
      r_cmp_hit <= 1'b0;
      r_cmp_k   <= '0;
      r_cmp_x   <= '0;
      r_cmp_y   <= '0;
    end else if (r_state == SCAN) begin
      r_cmp_vld <= 1'b1;
      r_cmp_hit <= w_hit & w_cand_vld;
      r_cmp_k   <= r_k;
      r_cmp_x   <= w_hx;
      r_cmp_y   <= w_hy;
      r_k       <= r_k + HIDX_W'(1);
    end else begin
      r_k       <= '0;
      r_cmp_vld <= 1'b0;
      if (i_frame_tick && i_enable) begin
        r_bx <= i_bl_x;
        r_by <= i_bl_y;
      end
    end
  end

  // Result/animation registers; abort clears them exactly like reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_fall_frame <= '0;
      r_hole_idx   <= '0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_win        <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pos_x <= i_bl_pos_initial_x;
          r_pos_y <= i_bl_pos_initial_y;
        end
        SCAN: if (w_scan_hit) begin
          r_hole_idx   <= r_cmp_k;
          r_pos_x      <= r_cmp_x;
          r_pos_y      <= r_cmp_y;
          r_fall_frame <= '0;
        end
        FALL: if (i_frame_tick) begin
          if (r_fall_frame == LAST_FRAME) begin
            r_win  <= (r_hole_idx == HIDX_W'(WIN_IDX));
            r_fail <= (r_hole_idx != HIDX_W'(WIN_IDX));
          end else begin
            r_fall_frame <= r_fall_frame + FF_W'(1);
          end
        end
        DONE: if (i_ack) begin
          r_win        <= 1'b0;
          r_fail       <= 1'b0;
          r_hole_idx   <= '0;
          r_fall_frame <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_falling    = r_falling;
  assign o_fall_frame = r_fall_frame;
  assign o_hole_idx   = r_hole_idx;
  assign o_pos_fall_x = r_pos_x;
  assign o_pos_fall_y = r_pos_y;
  assign o_win        = r_win;
  assign o_fail       = r_fail;

endmodule

// File: tb/tb_hole_fall_sequencer.sv
// Directed bench for hole_fall_sequencer: default build plus a
// FAILHOLE_NUM=15 / FALL_FRAMES=1 build, results checked via a scoreboard.
module tb_hole_fall_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en1, tick1, ack1, en2, tick2, ack2;
  logic [9:0]  bx, by, whx, why, rx, ry;
  logic [69:0] fhx1, fhy1;
  logic [6:0]  fhv1;
  logic [149:0] fhx2, fhy2;
  logic [14:0] fhv2;

  logic       busy1, falling1, win1, fail1;
  logic [2:0] ff1, idx1;
  logic [9:0] px1, py1;
  logic       busy2, falling2, win2, fail2;
  logic [0:0] ff2;
  logic [3:0] idx2;
  logic [9:0] px2, py2;

  hole_fall_sequencer #(.RADIUS(16), .FAILHOLE_NUM(7), .FALL_FRAMES(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en1), .i_frame_tick(tick1),
    .i_bl_x(bx), .i_bl_y(by), .i_wh_pos_x(whx), .i_wh_pos_y(why),
    .i_fh_pos_x(fhx1), .i_fh_pos_y(fhy1), .i_fh_valid(fhv1),
    .i_bl_pos_initial_x(rx), .i_bl_pos_initial_y(ry), .i_ack(ack1),
    .o_busy(busy1), .o_falling(falling1), .o_fall_frame(ff1), .o_hole_idx(idx1),
    .o_pos_fall_x(px1), .o_pos_fall_y(py1), .o_win(win1), .o_fail(fail1)
  );

  hole_fall_sequencer #(.RADIUS(16), .FAILHOLE_NUM(15), .FALL_FRAMES(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_frame_tick(tick2),
    .i_bl_x(bx), .i_bl_y(by), .i_wh_pos_x(whx), .i_wh_pos_y(why),
    .i_fh_pos_x(fhx2), .i_fh_pos_y(fhy2), .i_fh_valid(fhv2),
    .i_bl_pos_initial_x(rx), .i_bl_pos_initial_y(ry), .i_ack(ack2),
    .o_busy(busy2), .o_falling(falling2), .o_fall_frame(ff2), .o_hole_idx(idx2),
    .o_pos_fall_x(px2), .o_pos_fall_y(py2), .o_win(win2), .o_fail(fail2)
  );

  typedef struct {
    logic       win;
    logic       fail;
    logic [3:0] idx;
    logic [9:0] x;
    logic [9:0] y;
  } res_t;

  res_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    tick1 = 1'b1;
    step();
    tick1 = 1'b0;
  endtask

  // Frame ticks separated by an idle cycle.
  task automatic fall1(input int n);
    for (int i = 0; i < n; i++) begin
      tick1 = 1'b1;
      step();
      tick1 = 1'b0;
      step();
    end
  endtask

  task automatic check_res(input logic w, input logic f, input logic [3:0] idx,
                           input logic [9:0] x, input logic [9:0] y);
    res_t e;
    chk("sb_pending", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_win",  32'(w),   32'(e.win));
      chk("res_fail", 32'(f),   32'(e.fail));
      chk("res_idx",  32'(idx), 32'(e.idx));
      chk("res_x",    32'(x),   32'(e.x));
      chk("res_y",    32'(y),   32'(e.y));
    end
  endtask

  task automatic far_holes();
    whx = 10'd900;
    why = 10'd900;
    for (int j = 0; j < 7; j++) begin
      fhx1[10*j +: 10] = 10'(20 + 60 * j);
      fhy1[10*j +: 10] = 10'd900;
    end
    fhv1 = '1;
    for (int j = 0; j < 15; j++) begin
      fhx2[10*j +: 10] = 10'(20 + 60 * j);
      fhy2[10*j +: 10] = 10'd900;
    end
    fhv2 = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en1 = 1'b0; tick1 = 1'b0; ack1 = 1'b0;
    en2 = 1'b0; tick2 = 1'b0; ack2 = 1'b0;
    bx = '0; by = '0; rx = 10'd320; ry = 10'd240;
    far_holes();
    repeat (3) step();
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_falling", 32'(falling1), 0);
    chk("rst_px", 32'(px1), 0);
    chk("rst_win", 32'(win1), 0);
    chk("rst_fail", 32'(fail1), 0);
    chk("rst_px2", 32'(px2), 0);
    rst = 1'b0;
    step();
    chk("idle_respawn_x", 32'(px1), 320);
    chk("idle_respawn_y", 32'(py1), 240);
    en1 = 1'b1;

    // Win hole and fail slot 0 both on the ball: win has priority.
    bx = 10'd100; by = 10'd100; whx = 10'd100; why = 10'd100;
    fhx1[9:0] = 10'd100; fhy1[9:0] = 10'd100;
    pulse1();
    n = 0;
    while (!falling1 && n < 50) begin step(); n++; end
    chk("win_latency", 32'(n), 2);
    chk("win_idx", 32'(idx1), 0);
    chk("win_pos_x", 32'(px1), 100);
    chk("win_frame0", 32'(ff1), 0);
    sb.push_back('{win: 1'b1, fail: 1'b0, idx: 4'd0, x: 10'd100, y: 10'd100});
    for (int i = 1; i < 8; i++) begin
      tick1 = 1'b1; step(); tick1 = 1'b0;
      chk("win_frame", 32'(ff1), 32'(i));
      chk("win_not_yet", 32'(win1), 0);
      step();
    end
    tick1 = 1'b1; step(); tick1 = 1'b0;
    check_res(win1, fail1, 4'(idx1), px1, py1);
    chk("win_done_frame", 32'(ff1), 7);
    chk("win_done_falling", 32'(falling1), 0);
    chk("win_done_busy", 32'(busy1), 1);
    ack1 = 1'b1; step(); ack1 = 1'b0;
    chk("win_ack_win", 32'(win1), 0);
    chk("win_ack_busy", 32'(busy1), 0);

    // Slot 2 at exactly the radius misses, slot 3 inside hits.
    far_holes();
    bx = 10'd200; by = 10'd200;
    fhx1[29:20] = 10'd216; fhy1[29:20] = 10'd200;
    fhx1[39:30] = 10'd210; fhy1[39:30] = 10'd210;
    pulse1();
    n = 0;
    while (!falling1 && n < 50) begin step(); n++; end
    chk("fail3_latency", 32'(n), 6);
    chk("fail3_idx", 32'(idx1), 4);
    chk("fail3_pos_x", 32'(px1), 210);
    chk("fail3_pos_y", 32'(py1), 210);
    sb.push_back('{win: 1'b0, fail: 1'b1, idx: 4'd4, x: 10'd210, y: 10'd210});
    ack1 = 1'b1; step(); ack1 = 1'b0;
    chk("ack_in_fall", 32'(falling1), 1);
    fall1(7);
    chk("fail3_frame7", 32'(ff1), 7);
    chk("fail3_not_yet", 32'(fail1), 0);
    tick1 = 1'b1; step(); tick1 = 1'b0;
    check_res(win1, fail1, 4'(idx1), px1, py1);
    en1 = 1'b0;
    repeat (3) step();
    chk("done_hold_fail", 32'(fail1), 1);
    chk("done_hold_idx", 32'(idx1), 4);
    chk("done_hold_px", 32'(px1), 210);
    en1 = 1'b1;
    ack1 = 1'b1; step(); ack1 = 1'b0;
    chk("fail3_ack_fail", 32'(fail1), 0);
    chk("fail3_ack_idx", 32'(idx1), 0);
    chk("fail3_ack_frame", 32'(ff1), 0);
    chk("fail3_ack_busy", 32'(busy1), 0);

    // Ball on invalid slot 1: full scan, no result.
    far_holes();
    fhv1[1] = 1'b0;
    bx = 10'd80; by = 10'd900;
    pulse1();
    rx = 10'd500; ry = 10'd400;
    step();
    chk("miss_busy", 32'(busy1), 1);
    n = 1;
    while (busy1 && n < 50) begin step(); n++; end
    chk("miss_latency", 32'(n), 9);
    chk("miss_falling", 32'(falling1), 0);
    chk("miss_fail", 32'(fail1), 0);
    chk("miss_pos_hold", 32'(px1), 320);
    step();
    chk("miss_respawn_x", 32'(px1), 500);
    chk("miss_respawn_y", 32'(py1), 400);

    // Abort during FALL at frame 3 (slot 5 hit).
    fhv1 = '1;
    bx = 10'd320; by = 10'd900;
    pulse1();
    n = 0;
    while (!falling1 && n < 50) begin step(); n++; end
    chk("slot5_latency", 32'(n), 8);
    chk("slot5_idx", 32'(idx1), 6);
    fall1(3);
    chk("abort_pre_frame", 32'(ff1), 3);
    en1 = 1'b0;
    step();
    chk("abort_falling", 32'(falling1), 0);
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_frame", 32'(ff1), 0);
    chk("abort_idx", 32'(idx1), 0);
    chk("abort_px", 32'(px1), 0);
    step();
    chk("abort_respawn", 32'(px1), 500);
    pulse1();
    step();
    chk("tick_disabled", 32'(busy1), 0);
    en1 = 1'b1;

    // Reset held for 3 cycles mid-FALL.
    pulse1();
    n = 0;
    while (!falling1 && n < 50) begin step(); n++; end
    fall1(2);
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(busy1), 0);
    chk("midrst_falling", 32'(falling1), 0);
    chk("midrst_frame", 32'(ff1), 0);
    chk("midrst_idx", 32'(idx1), 0);
    step(); step();
    chk("midrst_px", 32'(px1), 0);
    rst = 1'b0;
    step();
    chk("postrst_px", 32'(px1), 500);
    chk("postrst_busy", 32'(busy1), 0);

    // 15 slots, single-frame animation, hit on slot 14.
    en2 = 1'b1;
    bx = 10'd860; by = 10'd900;
    tick2 = 1'b1; step(); tick2 = 1'b0;
    n = 0;
    while (!falling2 && n < 50) begin step(); n++; end
    chk("s14_latency", 32'(n), 17);
    chk("s14_idx", 32'(idx2), 15);
    chk("s14_frame", 32'(ff2), 0);
    sb.push_back('{win: 1'b0, fail: 1'b1, idx: 4'd15, x: 10'd860, y: 10'd900});
    tick2 = 1'b1; step(); tick2 = 1'b0;
    check_res(win2, fail2, idx2, px2, py2);
    chk("s14_done_frame", 32'(ff2), 0);
    chk("s14_done_falling", 32'(falling2), 0);
    ack2 = 1'b1; step(); ack2 = 1'b0;
    chk("s14_ack_fail", 32'(fail2), 0);
    chk("s14_ack_idx", 32'(idx2), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
